decoder_n: RTL and testbench
============================

// Module: decoder_n
// PURPOSE
//  Parameterised N-to-M binary-to-one-hot decoder with combinational output and a registered copy.
//  Used for select-line and address-to-row decode in datapath and register-file logic.
//  The combinational path settles within the same delta cycle as `in`.
//  The registered path gives a clean flop boundary for timing-critical consumers.
// PARAMETERS
//  N   4       width of binary input code
//  M   1<<N    number of one-hot outputs; legal range 1..2**N, elaboration error otherwise
// PORTS
//  clk      in   1  clock; all flops sample on rising edge
//  rst      in   1  reset, asynchronous, active-high
//  en       in   1  decode enable; low forces all outputs to zero
//  in       in   N  binary code to decode
//  y        out  M  combinational one-hot decode of in
//  oor      out  1  combinational: en=1 and in >= M (code out of range)
//  y_q      out  M  registered y
//  oor_q    out  1  registered oor
// BEHAVIOUR
//  - Combinational: y[k] = en && (in == k) for k in 0..M-1; at most one bit set.
//  - in >= M with en=1: y = 0, oor = 1. With en=0: y = 0, oor = 0.
//  - M == 2**N: oor is constant 0.
//  - X/Z on in or en propagates to X on y (no masking); y has no other state.
//  - Registered: y_q <= y, oor_q <= oor on every rising clk; latency exactly 1 cycle.
//  - No load enable: y_q follows y every cycle, including when en=0, in which case it loads zeros.
//  - rst asserted (async, active-high): y_q = 0 and oor_q = 0 immediately, held while rst=1.
//  - First edge after rst deasserts loads the current decode; no extra dead cycle.
//  - Reset mid-operation: registered outputs clear at once; combinational y is unaffected by rst.
//  - Reset values: y_q = 0, oor_q = 0; y/oor have no reset (pure function of en and in).
// CONFIGURATION
//  DECODE_ONEHOT_CHK_EN defined:
//    - Adds output onehot_err (1 bit, registered, reset 0).
//    - onehot_err <= 1 when y has more than one bit set, or when en=1 with in < M and y == 0.
//    - Flag is sticky until rst.
//    - Includes a simulation-only $error on the same condition.
//  DECODE_ONEHOT_CHK_EN undefined: port and logic absent; no other behaviour changes.
// STRUCTURE
//  - Package decode_pkg holds:
//    - localparam DEC_N_DEF = 4 and DEC_M_DEF = 16
//    - function onehot_f(code, en) returning the M-bit decode
//    - function is_onehot0(vec) used by the checker
//  - One sub-module, decode_comb:
//    - N/M parameters; en, in -> y, oor; purely combinational.
//    - Reused by other blocks needing an unregistered decode.
//  - Top level decoder_n = decode_comb + output register stage + optional checker.
// TESTING
//  - Exhaustive, N=4, M=16, en=1:
//    - sweep in 0..15 with 1 time-unit settle -> y == 1<<in every step, oor=0.
//    - y_q equals the previous step's y one clk later.
//  - en=0 with in=4'b0101 -> y=16'h0000, oor=0; next clk y_q=0.
//  - Out of range, N=4, M=10, en=1:
//    - in=9 -> y=10'b10_0000_0000, oor=0.
//    - in=12 -> y=0, oor=1; next clk oor_q=1.
//  - Async reset:
//    - in=3, clk running, y_q=16'h0008.
//    - Assert rst between edges -> y_q=0 before the next edge.
//    - Release rst -> y_q=16'h0008 after the first edge.
//  - Minimum size, N=1, M=2: in=0 -> y=2'b01; in=1 -> y=2'b10.
//  - DECODE_ONEHOT_CHK_EN defined:
//    - Full sweep -> onehot_err stays 0.
//    - Force y to 16'h0003 -> onehot_err=1 next clk, held until rst.

Source files
------------

// File: rtl/decode_pkg.sv
// ============================================================================
// Module  : decode_pkg
// Desc    : Shared constants and helper functions for the binary-to-one-hot decoders.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  localparam int DEC_N_DEF = 4;
  localparam int DEC_M_DEF = 16;

  // Helpers work on a fixed maximum width; callers zero-extend or slice to M.
  localparam int DEC_CODE_W = 10;
  localparam int DEC_M_MAX  = 1 << DEC_CODE_W;

  function automatic logic [DEC_M_MAX-1:0] onehot_f(
    input logic [DEC_CODE_W-1:0] code,
    input logic                  en
  );
    logic [DEC_M_MAX-1:0] r_vec;
    for (int k = 0; k < DEC_M_MAX; k++) begin
      r_vec[k] = en & (code == DEC_CODE_W'(k));
    end
    return r_vec;
  endfunction

  function automatic logic is_onehot0(input logic [DEC_M_MAX-1:0] vec);
    return (vec & (vec - DEC_M_MAX'(1))) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_comb.sv
// ============================================================================
// Module  : decode_comb
// Desc    : Purely combinational N-bit binary to M-bit one-hot decode with range flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module decode_comb
  import decode_pkg::*;
#(
  parameter int N = DEC_N_DEF,
  parameter int M = 1 << N
) (
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [M-1:0] y,
  output logic         oor
);

  if ((M < 1) || (M > (1 << N))) begin : g_bad_m
    $error("decode_comb: M=%0d outside legal range 1..%0d", M, 1 << N);
  end

  // Per-bit equality keeps X on en/in visible on y instead of masking it.
  for (genvar k = 0; k < M; k++) begin : g_bit
    assign y[k] = en & (in == N'(k));
  end

  if (M < (1 << N)) begin : g_oor
    assign oor = en & (in >= N'(M));
  end else begin : g_no_oor
    assign oor = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/decoder_n.sv
// ============================================================================
// Module  : decoder_n
// Desc    : One-hot decoder with combinational and registered outputs.
//           DECODE_ONEHOT_CHK_EN adds a sticky one-hot integrity flag (onehot_err).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder_n
  import decode_pkg::*;
#(
  parameter int N = DEC_N_DEF,
  parameter int M = 1 << N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] in,
  output logic [M-1:0] y,
  output logic         oor,
  output logic [M-1:0] y_q,
  output logic         oor_q
`ifdef DECODE_ONEHOT_CHK_EN
  ,
  output logic         onehot_err
`endif
);

  logic [M-1:0] w_y;
  logic         w_oor;
  logic [M-1:0] r_y_q;
  logic         r_oor_q;

  decode_comb #(
    .N (N),
    .M (M)
  ) u_decode_comb (
    .en  (en),
    .in  (in),
    .y   (w_y),
    .oor (w_oor)
  );

  assign y     = w_y;
  assign oor   = w_oor;
  assign y_q   = r_y_q;
  assign oor_q = r_oor_q;

  // No load enable: the register tracks the decode every cycle, zeros included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y_q   <= '0;
      r_oor_q <= 1'b0;
    end else begin
      r_y_q   <= w_y;
      r_oor_q <= w_oor;
    end
  end

`ifdef DECODE_ONEHOT_CHK_EN
  localparam logic [N:0] c_m_ext = (N + 1)'(M);

  logic w_chk_bad;
  logic r_onehot_err;

  // Bad when several bits are hot, or when an in-range enabled code decodes to nothing.
  assign w_chk_bad = !is_onehot0(DEC_M_MAX'(w_y)) ||
                     (en && ({1'b0, in} < c_m_ext) && (w_y == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_onehot_err <= 1'b0;
    end else if (w_chk_bad) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && w_chk_bad) begin
      $error("decoder_n: one-hot violation y=%0h en=%0b in=%0d", w_y, en, in);
    end
  end
`endif
`endif

endmodule

`default_nettype wire

// File: tb/tb_decoder_n.sv
// ============================================================================
// Module  : tb_decoder_n
// Desc    : Self-checking bench for decoder_n at (N,M) = (4,16), (4,10) and (1,2).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decoder_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  in4;
  logic        in1;

  logic [15:0] y16, yq16;
  logic        oor16, oorq16;
  logic [9:0]  y10, yq10;
  logic        oor10, oorq10;
  logic [1:0]  y1, yq1;
  logic        oor1, oorq1;
`ifdef DECODE_ONEHOT_CHK_EN
  logic        err16, err10, err1;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_n #(.N(4), .M(16)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in4),
    .y(y16), .oor(oor16), .y_q(yq16), .oor_q(oorq16)
`ifdef DECODE_ONEHOT_CHK_EN
    , .onehot_err(err16)
`endif
  );

  decoder_n #(.N(4), .M(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .in(in4),
    .y(y10), .oor(oor10), .y_q(yq10), .oor_q(oorq10)
`ifdef DECODE_ONEHOT_CHK_EN
    , .onehot_err(err10)
`endif
  );

  decoder_n #(.N(1), .M(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in(in1),
    .y(y1), .oor(oor1), .y_q(yq1), .oor_q(oorq1)
`ifdef DECODE_ONEHOT_CHK_EN
    , .onehot_err(err1)
`endif
  );

  // Reference model: a set bit at position 'code' when enabled and in range.
  function automatic logic [15:0] ref_y(input logic e, input int code, input int m);
    return (e && code < m) ? (16'(1) << code) : 16'h0000;
  endfunction

  function automatic logic ref_oor(input logic e, input int code, input int m);
    return e && (code >= m);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  in;
    logic [15:0] y16;
    logic [9:0]  y10;
    logic        oor10;
  } vec_t;

  vec_t tbl[7];

  logic [15:0] e16, e10, e1;
  logic        eo16, eo10, eo1;

  initial begin
    tbl[0] = '{1'b1, 4'd0,  16'h0001, 10'h001, 1'b0};
    tbl[1] = '{1'b1, 4'd9,  16'h0200, 10'h200, 1'b0};
    tbl[2] = '{1'b1, 4'd12, 16'h1000, 10'h000, 1'b1};
    tbl[3] = '{1'b0, 4'd5,  16'h0000, 10'h000, 1'b0};
    tbl[4] = '{1'b1, 4'd15, 16'h8000, 10'h000, 1'b1};
    tbl[5] = '{1'b0, 4'd12, 16'h0000, 10'h000, 1'b0};
    tbl[6] = '{1'b1, 4'd10, 16'h0400, 10'h000, 1'b1};

    rst = 1'b1; en = 1'b0; in4 = 4'd0; in1 = 1'b0;
    #1;
    check("reset_yq16", yq16, 0);
    check("reset_oorq16", oorq16, 0);
    check("reset_yq10", yq10, 0);
    check("reset_oorq10", oorq10, 0);
    en = 1'b1; in4 = 4'd3;
    @(posedge clk); #1;
    check("reset_hold_yq16", yq16, 0);
    check("reset_comb_y16", y16, 16'h0008);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      en = tbl[i].en; in4 = tbl[i].in;
      #1;
      check("tbl_y16", y16, tbl[i].y16);
      check("tbl_oor16", oor16, 0);
      check("tbl_y10", y10, tbl[i].y10);
      check("tbl_oor10", oor10, tbl[i].oor10);
      @(posedge clk); #1;
      check("tbl_yq16", yq16, tbl[i].y16);
      check("tbl_yq10", yq10, tbl[i].y10);
      check("tbl_oorq10", oorq10, tbl[i].oor10);
    end

    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      en = 1'b1; in4 = 4'(c);
      #1;
      check("sweep_y16", y16, 16'(1) << c);
      check("sweep_oor16", oor16, 0);
      @(posedge clk); #1;
      check("sweep_yq16", yq16, 16'(1) << c);
    end

    for (int r = 0; r < 200; r++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 3) != 0);
      in4 = 4'($urandom_range(0, 15));
      in1 = 1'($urandom_range(0, 1));
      e16 = ref_y(en, int'(in4), 16); eo16 = ref_oor(en, int'(in4), 16);
      e10 = ref_y(en, int'(in4), 10); eo10 = ref_oor(en, int'(in4), 10);
      e1  = ref_y(en, int'(in1), 2);  eo1  = ref_oor(en, int'(in1), 2);
      #1;
      check("rnd_y16", y16, e16);
      check("rnd_oor16", oor16, eo16);
      check("rnd_y10", y10, e10);
      check("rnd_oor10", oor10, eo10);
      check("rnd_y1", y1, e1);
      check("rnd_oor1", oor1, eo1);
      @(posedge clk); #1;
      check("rnd_yq16", yq16, e16);
      check("rnd_oorq16", oorq16, eo16);
      check("rnd_yq10", yq10, e10);
      check("rnd_oorq10", oorq10, eo10);
      check("rnd_yq1", yq1, e1);
      check("rnd_oorq1", oorq1, eo1);
    end

    // Asynchronous reset in the middle of a cycle, then release.
    @(negedge clk);
    en = 1'b1; in4 = 4'd3;
    @(posedge clk); #1;
    check("ar_pre_yq16", yq16, 16'h0008);
    #2 rst = 1'b1;
    #1;
    check("ar_async_yq16", yq16, 0);
    check("ar_comb_y16", y16, 16'h0008);
    @(posedge clk); #1;
    check("ar_held_yq16", yq16, 0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("ar_rel_yq16", yq16, 0);
    @(posedge clk); #1;
    check("ar_first_edge_yq16", yq16, 16'h0008);

    @(negedge clk);
    en = 1'b1; in1 = 1'b0;
    #1;
    check("n1_in0_y1", y1, 2'b01);
    in1 = 1'b1;
    #1;
    check("n1_in1_y1", y1, 2'b10);
    check("n1_oor1", oor1, 0);

`ifdef DECODE_ONEHOT_CHK_EN
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      en = 1'b1; in4 = 4'(c); in1 = c[0];
      @(posedge clk); #1;
    end
    check("chk_sweep_err16", err16, 0);
    check("chk_sweep_err10", err10, 0);
    check("chk_sweep_err1", err1, 0);
    @(negedge clk);
    force dut.w_y = 16'h0003;
    @(posedge clk); #1;
    check("chk_force_err16", err16, 1);
    @(negedge clk);
    release dut.w_y;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("chk_sticky_err16", err16, 1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("chk_rst_err16", err16, 0);
    @(negedge clk); rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
